// File: rtl/text_render_unit.sv
// text_render_unit: multi-character text rasteriser.
//
// Latches a string descriptor, fetches each character code from text memory
// and each glyph row from the font ROM (both with fixed 1-cycle read latency),
// then streams one coloured pixel per cycle over a valid/ready handshake.
// All outputs are registered.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   start, busy, done                request / busy flag / completion pulse
//   base_addr, len, x0, y0           string descriptor
//   fg_color, bg_color               colours for font bits 1 and 0
//   char_rd, addr_out, char_in       text-memory read port
//   font_rd, font_addr, font_data    font-ROM read port (bit 0 = leftmost)
//   pix_valid, pix_ready             pixel handshake
//   pix_x, pix_y, pix_color          pixel payload
//
// Build option TEXT_RENDER_TRANSPARENT_EN adds input `transparent`: when the
// latched value is 1, background pixels are skipped (1 cycle each, no valid).
// FONT_AW must be at least 8 + clog2(GLYPH_H).
module text_render_unit #(
  parameter int unsigned GLYPH_W = 8,
  parameter int unsigned GLYPH_H = 16,
  parameter int unsigned COLOR_W = 4,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned FONT_AW = 12,
  parameter int unsigned LEN_W   = 6,
  parameter int unsigned COORD_W = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [LEN_W-1:0]   len,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COLOR_W-1:0] fg_color,
  input  logic [COLOR_W-1:0] bg_color,
`ifdef TEXT_RENDER_TRANSPARENT_EN
  input  logic               transparent,
`endif
  output logic               busy,
  output logic               done,
  output logic               char_rd,
  output logic [ADDR_W-1:0]  addr_out,
  input  logic [7:0]         char_in,
  output logic               font_rd,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [GLYPH_W-1:0] font_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COLOR_W-1:0] pix_color
);

  localparam int unsigned RowW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int unsigned ColW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;

  typedef enum logic [2:0] {
    StIdle, StCharRd, StCharWait, StRowRd, StRowWait, StPixel, StDone
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  base_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   char_idx_q;
  logic [COORD_W-1:0] char_x_q;   // x of the current glyph's left column
  logic [COORD_W-1:0] y0_q;
  logic [COLOR_W-1:0] fg_q;
  logic [COLOR_W-1:0] bg_q;
  logic               trans_q;
  logic [7:0]         char_code_q;
  logic [RowW-1:0]    row_q;
  logic [ColW-1:0]    col_q;
  logic [GLYPH_W-1:0] row_bits_q;

`ifndef TEXT_RENDER_TRANSPARENT_EN
  assign trans_q = 1'b0;
`endif

  logic            last_col, last_row, last_char, next_bit, pixel_step;
  logic [ColW-1:0] col_nxt;
  logic [LEN_W-1:0] char_idx_nxt;

  always_comb begin
    last_col     = (col_q == ColW'(GLYPH_W - 1));
    last_row     = (row_q == RowW'(GLYPH_H - 1));
    last_char    = (char_idx_q == len_q - LEN_W'(1));
    col_nxt      = col_q + ColW'(1);
    char_idx_nxt = char_idx_q + LEN_W'(1);
    next_bit     = row_bits_q[col_nxt];
    // Skipped (transparent) pixels advance without waiting for ready.
    pixel_step   = pix_valid ? pix_ready : 1'b1;
  end

  function automatic logic [FONT_AW-1:0] glyph_addr(input logic [7:0] code,
                                                    input logic [RowW-1:0] r);
    return FONT_AW'(code) * FONT_AW'(GLYPH_H) + FONT_AW'(r);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      char_idx_q  <= '0;
      char_x_q    <= '0;
      y0_q        <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
`ifdef TEXT_RENDER_TRANSPARENT_EN
      trans_q     <= 1'b0;
`endif
      char_code_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      row_bits_q  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      char_rd     <= 1'b0;
      addr_out    <= '0;
      font_rd     <= 1'b0;
      font_addr   <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_color   <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      char_rd <= 1'b0;
      font_rd <= 1'b0;
      done    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            base_q     <= base_addr;
            len_q      <= len;
            char_x_q   <= x0;
            y0_q       <= y0;
            fg_q       <= fg_color;
            bg_q       <= bg_color;
`ifdef TEXT_RENDER_TRANSPARENT_EN
            trans_q    <= transparent;
`endif
            char_idx_q <= '0;
            busy       <= 1'b1;
            if (len == '0) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              char_rd  <= 1'b1;
              addr_out <= base_addr;
              state_q  <= StCharRd;
            end
          end
        end
        StCharRd: state_q <= StCharWait;
        StCharWait: begin
          char_code_q <= char_in;
          row_q       <= '0;
          font_rd     <= 1'b1;
          font_addr   <= glyph_addr(char_in, '0);
          state_q     <= StRowRd;
        end
        StRowRd: state_q <= StRowWait;
        StRowWait: begin
          row_bits_q <= font_data;
          col_q      <= '0;
          pix_x      <= char_x_q;
          pix_y      <= y0_q + COORD_W'(row_q);
          pix_color  <= font_data[0] ? fg_q : bg_q;
          pix_valid  <= font_data[0] | ~trans_q;
          state_q    <= StPixel;
        end
        StPixel: begin
          if (pixel_step) begin
            if (!last_col) begin
              col_q     <= col_nxt;
              pix_x     <= pix_x + COORD_W'(1);
              pix_color <= next_bit ? fg_q : bg_q;
              pix_valid <= next_bit | ~trans_q;
            end else begin
              pix_valid <= 1'b0;
              if (!last_row) begin
                row_q     <= row_q + RowW'(1);
                font_rd   <= 1'b1;
                font_addr <= glyph_addr(char_code_q, row_q + RowW'(1));
                state_q   <= StRowRd;
              end else if (!last_char) begin
                char_idx_q <= char_idx_nxt;
                char_x_q   <= char_x_q + COORD_W'(GLYPH_W);
                char_rd    <= 1'b1;
                addr_out   <= base_q + ADDR_W'(char_idx_nxt);
                state_q    <= StCharRd;
              end else begin
                done    <= 1'b1;
                state_q <= StDone;
              end
            end
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_text_render_unit.sv
// Self-checking bench for text_render_unit (default 8x16 parameters).
// Text memory and font ROM are modelled as arrays with 1-cycle read latency;
// expected pixels are computed directly from the descriptor and memory
// contents, then compared against each presented pixel.
module tb_text_render_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [11:0] base_addr;
  logic [5:0]  len;
  logic [9:0]  x0, y0;
  logic [3:0]  fg_color, bg_color;
`ifdef TEXT_RENDER_TRANSPARENT_EN
  logic        transparent;
`endif
  logic        busy, done, char_rd, font_rd, pix_valid, pix_ready;
  logic [11:0] addr_out, font_addr;
  logic [7:0]  char_in, font_data;
  logic [9:0]  pix_x, pix_y;
  logic [3:0]  pix_color;

  logic [7:0] text_mem [4096];
  logic [7:0] font_rom [4096];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  text_render_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .x0        (x0),
    .y0        (y0),
    .fg_color  (fg_color),
    .bg_color  (bg_color),
`ifdef TEXT_RENDER_TRANSPARENT_EN
    .transparent (transparent),
`endif
    .busy      (busy),
    .done      (done),
    .char_rd   (char_rd),
    .addr_out  (addr_out),
    .char_in   (char_in),
    .font_rd   (font_rd),
    .font_addr (font_addr),
    .font_data (font_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color)
  );

  // Memories answer one cycle after the strobe; junk otherwise.
  always @(posedge clk) begin
    char_in   <= char_rd ? text_mem[addr_out] : 8'($urandom);
    font_data <= font_rd ? font_rom[font_addr] : 8'($urandom);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {11'd0, busy, done, char_rd, font_rd, pix_valid, addr_out, font_addr,
            pix_x, pix_y, pix_color};
  endfunction

  task automatic scramble();
    base_addr = 12'($urandom);
    len       = 6'($urandom_range(1, 63));
    x0        = 10'($urandom);
    y0        = 10'($urandom);
    fg_color  = 4'($urandom);
    bg_color  = 4'($urandom);
`ifdef TEXT_RENDER_TRANSPARENT_EN
    transparent = 1'($urandom);
`endif
  endtask

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run_string(input logic [11:0] b, input logic [5:0] n, input logic [9:0] xo,
                            input logic [9:0] yo, input logic [3:0] fg, input logic [3:0] bg,
                            input logic tr, input int mode, input int abort_at,
                            input bit poke, input bit timing);
    logic [23:0] expq[$];
    logic [11:0] addrq[$];
    logic [7:0]  code, bits;
    logic        tr_eff;
    int cyc, n_char, n_font, n_pix, total, limit;
    int first_char, first_font, first_pix, done_cyc;
    bit done_seen, aborted;
`ifdef TEXT_RENDER_TRANSPARENT_EN
    tr_eff = tr;
`else
    tr_eff = 1'b0;
`endif
    for (int i = 0; i < int'(n); i++) begin
      addrq.push_back(12'(int'(b) + i));
      code = text_mem[12'(int'(b) + i)];
      for (int r = 0; r < 16; r++) begin
        bits = font_rom[12'(int'(code) * 16 + r)];
        for (int c = 0; c < 8; c++)
          if (bits[c] || !tr_eff)
            expq.push_back({10'(int'(xo) + i * 8 + c), 10'(int'(yo) + r),
                            bits[c] ? fg : bg});
      end
    end
    total = expq.size();
    limit = int'(n) * 400 + 10;
    n_char = 0; n_font = 0; n_pix = 0;
    first_char = -1; first_font = -1; first_pix = -1; done_cyc = -1;
    done_seen = 0; aborted = 0;

    @(negedge clk);
    base_addr = b; len = n; x0 = xo; y0 = yo; fg_color = fg; bg_color = bg;
`ifdef TEXT_RENDER_TRANSPARENT_EN
    transparent = tr;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();   // descriptor changes after acceptance must not matter
    cyc = 1;
    while (!done_seen && !aborted && cyc <= limit) begin
      if (cyc == 1) check("busy_after_accept", busy, 1);
      if (cyc == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("outputs_zero_on_reset", all_outs(), 0);
        aborted = 1;
      end else begin
        if (char_rd) begin
          n_char++;
          if (first_char < 0) first_char = cyc;
          if (addrq.size() > 0) check("addr_out", addr_out, addrq.pop_front());
        end
        if (font_rd) begin
          n_font++;
          if (first_font < 0) first_font = cyc;
        end
        case (mode)
          0:       pix_ready = 1'b1;
          1:       pix_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: pix_ready = 1'($urandom);
        endcase
        if (pix_valid) begin
          if (first_pix < 0) first_pix = cyc;
          if (expq.size() == 0) begin
            check("pixel_overrun", n_pix + 1, total);
          end else begin
            check("pixel", {pix_x, pix_y, pix_color}, expq[0]);
            if (pix_ready) void'(expq.pop_front());
          end
          if (pix_ready) n_pix++;
        end
        if (done) begin
          done_seen = 1;
          done_cyc  = cyc;
        end
        if (poke && cyc == 50) begin
          scramble();
          start = 1'b1;   // must be ignored while busy
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (aborted) begin
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
    end else begin
      check("done_seen", done_seen, 1);
      check("char_rd_count", n_char, n);
      check("font_rd_count", n_font, int'(n) * 16);
      check("pixel_count", n_pix, total);
      // done lands the cycle after the last pixel handshake.
      if (mode == 0) check("done_cycle", done_cyc, int'(n) * 162 + 1);
      if (timing) begin
        check("first_char_rd_cycle", first_char, 1);
        check("first_font_rd_cycle", first_font, 3);
        check("first_pix_valid_cycle", first_pix, 5);
      end
      @(negedge clk);
      check("done_single_cycle", done, 0);
      check("busy_cleared", busy, 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      text_mem[a] = 8'($urandom);
      font_rom[a] = 8'($urandom);
    end
    text_mem[16] = 8'h41;
    for (int r = 0; r < 16; r++) font_rom[12'h410 + r] = 8'h81;

    reset_n = 1'b0; start = 1'b0; pix_ready = 1'b0;
    base_addr = '0; len = '0; x0 = '0; y0 = '0; fg_color = '0; bg_color = '0;
`ifdef TEXT_RENDER_TRANSPARENT_EN
    transparent = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single 'A' glyph with rows 8'h81 at (16,32), fg F / bg 1.
    run_string(12'd16, 6'd1, 10'd16, 10'd32, 4'hF, 4'h1, 1'b0, 0, 0, 0, 1);
    // Address wrap at the top of text memory.
    run_string(12'hFFF, 6'd3, 10'd100, 10'd7, 4'h3, 4'hC, 1'b0, 0, 0, 0, 1);
    // Backpressure pattern plus a start pulse while busy.
    run_string(12'h123, 6'd2, 10'd40, 10'd50, 4'h9, 4'h6, 1'b0, 1, 0, 1, 0);
    // Empty string.
    run_string(12'h200, 6'd0, 10'd0, 10'd0, 4'h5, 4'hA, 1'b0, 0, 0, 0, 0);
    // x wraps 1023 -> 0 inside the glyph; y near the top also wraps.
    run_string(12'h300, 6'd2, 10'd1020, 10'd1015, 4'h7, 4'h2, 1'b0, 2, 0, 0, 0);
    // Reset in the middle of a row, then a clean render.
    run_string(12'h400, 6'd2, 10'd10, 10'd10, 4'h1, 4'h2, 1'b0, 0, 100, 0, 0);
    run_string(12'd16, 6'd1, 10'd16, 10'd32, 4'hF, 4'h1, 1'b0, 0, 0, 0, 1);
    // Randomised descriptors and readiness.
    for (int k = 0; k < 6; k++)
      run_string(12'($urandom), 6'($urandom_range(1, 3)), 10'($urandom), 10'($urandom),
                 4'($urandom), 4'($urandom), 1'b0, int'($urandom_range(0, 2)), 0,
                 1'($urandom), 0);
`ifdef TEXT_RENDER_TRANSPARENT_EN
    // Rows 8'h81 with background skipped: two pixels per row.
    run_string(12'd16, 6'd1, 10'd16, 10'd32, 4'hF, 4'h1, 1'b1, 0, 0, 0, 0);
    run_string(12'($urandom), 6'd2, 10'($urandom), 10'($urandom), 4'h4, 4'h8, 1'b1, 2, 0,
               0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
